// File: rtl/pe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : pe_pkg
// Description : Shared definitions for the pe_mac_param processing element.
//               Mode encodings, the pipeline op token and range helpers that
//               return min/max of a W-bit signed or unsigned quantity as a
//               64-bit pattern (callers slice off the width they need).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package pe_pkg;

  localparam logic [1:0] MODE_MAC_STREAM = 2'd0;
  localparam logic [1:0] MODE_MAC_STAT   = 2'd1;
  localparam logic [1:0] MODE_LOAD_W     = 2'd2;
  localparam logic [1:0] MODE_DRAIN      = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [1:0] mode;
  } op_t;

  // Largest representable value of a w-bit field (w < 64).
  function automatic logic [63:0] f_max(input int w, input logic sgn);
    if (sgn) return (64'd1 << (w - 1)) - 64'd1;
    return (64'd1 << w) - 64'd1;
  endfunction

  // Smallest representable value of a w-bit field, two's complement pattern.
  function automatic logic [63:0] f_min(input int w, input logic sgn);
    if (sgn) return ~((64'd1 << (w - 1)) - 64'd1);
    return 64'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_requant.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : pe_requant
// Description : Combinational requantiser. Shifts the accumulator right by
//               SHIFT (arithmetic when SIGNED) and clamps the result into the
//               DATA_W output range.
// Ports       : i_acc   - accumulator value (ACC_W)
//               o_val   - requantised, clamped value (DATA_W)
//               o_clamp - 1 when the shifted value did not fit and was clamped
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module pe_requant
  import pe_pkg::*;
#(
  parameter int ACC_W  = 20,
  parameter int DATA_W = 8,
  parameter int SHIFT  = 0,
  parameter int SIGNED = 0
) (
  input  logic [ACC_W-1:0]  i_acc,
  output logic [DATA_W-1:0] o_val,
  output logic              o_clamp
);

  logic [ACC_W-1:0] w_shifted;

  generate
    if (SIGNED != 0) begin : g_signed
      localparam logic [63:0]       c_max64 = f_max(DATA_W, 1'b1);
      localparam logic [63:0]       c_min64 = f_min(DATA_W, 1'b1);
      localparam logic [DATA_W-1:0] c_max   = c_max64[DATA_W-1:0];
      localparam logic [DATA_W-1:0] c_min   = c_min64[DATA_W-1:0];

      logic [ACC_W-DATA_W:0] w_upper;
      logic                  w_fits;

      assign w_shifted = $signed(i_acc) >>> SHIFT;
      // The value fits when everything above the output sign bit is a copy
      // of that sign bit.
      assign w_upper   = w_shifted[ACC_W-1:DATA_W-1];
      assign w_fits    = (&w_upper) | ~(|w_upper);
      assign o_clamp   = ~w_fits;
      assign o_val     = w_fits ? w_shifted[DATA_W-1:0]
                                : (w_shifted[ACC_W-1] ? c_min : c_max);
    end else begin : g_unsigned
      localparam logic [63:0]       c_max64 = f_max(DATA_W, 1'b0);
      localparam logic [DATA_W-1:0] c_max   = c_max64[DATA_W-1:0];

      assign w_shifted = i_acc >> SHIFT;
      assign o_clamp   = |w_shifted[ACC_W-1:DATA_W];
      assign o_val     = o_clamp ? c_max : w_shifted[DATA_W-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pe_mac_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : pe_mac_param
// Description : Parametrised systolic processing element with a stationary
//               weight register, a two-stage multiply/accumulate pipeline,
//               explicit drain with requantisation and overflow reporting.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               activate, mode_i         - op valid and op select
//               pe_in, pe_filter         - activation / filter (or weight)
//               pe_in_o, pe_filter_o,
//               activate_o, mode_o       - inputs forwarded one cycle later
//               pe_out, pe_out_valid,
//               pe_out_sat               - drained result, pulse, saturation
//               pe_psum                  - live accumulator
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module pe_mac_param
  import pe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int SIGNED = 0,
  parameter int SAT_EN = 1,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              activate,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] pe_in,
  input  logic [DATA_W-1:0] pe_filter,
  output logic [DATA_W-1:0] pe_in_o,
  output logic [DATA_W-1:0] pe_filter_o,
  output logic              activate_o,
  output logic [1:0]        mode_o,
  output logic [DATA_W-1:0] pe_out,
  output logic              pe_out_valid,
  output logic              pe_out_sat,
  output logic [ACC_W-1:0]  pe_psum
);

  localparam int          c_prod_w    = 2 * DATA_W;
  localparam int          c_ext_w     = ACC_W + 1 - c_prod_w;
  localparam logic        c_signed    = (SIGNED != 0);
  localparam logic [63:0] c_acc_max64 = f_max(ACC_W, c_signed);
  localparam logic [63:0] c_acc_min64 = f_min(ACC_W, c_signed);
  localparam logic [ACC_W-1:0] c_acc_max = c_acc_max64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] c_acc_min = c_acc_min64[ACC_W-1:0];

  logic [DATA_W-1:0]   r_w;
  op_t                 r_s1_op;
  logic [c_prod_w-1:0] r_s1_prod;
  logic [ACC_W-1:0]    r_acc;
  logic                r_ovf;

  logic [DATA_W-1:0]   w_mul_b;
  logic [c_prod_w-1:0] w_prod;
  logic [ACC_W:0]      w_acc_ext;
  logic [ACC_W:0]      w_prod_ext;
  logic [ACC_W:0]      w_sum;
  logic                w_sum_ovf;
  logic [ACC_W-1:0]    w_acc_next;
  logic [DATA_W-1:0]   w_rq_val;
  logic                w_rq_clamp;

  // The weight register is written at the capture edge, so a MAC_STAT in
  // the very next cycle already multiplies by the new weight.
  assign w_mul_b = (mode_i == MODE_MAC_STAT) ? r_w : pe_filter;

  // Operands are extended to the product width before multiplying so the
  // low 2*DATA_W bits hold the exact product in either signedness.
  generate
    if (SIGNED != 0) begin : g_mul_signed
      assign w_prod = $signed({{DATA_W{pe_in[DATA_W-1]}}, pe_in})
                    * $signed({{DATA_W{w_mul_b[DATA_W-1]}}, w_mul_b});
    end else begin : g_mul_unsigned
      assign w_prod = {{DATA_W{1'b0}}, pe_in} * {{DATA_W{1'b0}}, w_mul_b};
    end
  endgenerate

  // One guard bit above the accumulator catches overflow in both modes.
  assign w_acc_ext  = {c_signed & r_acc[ACC_W-1], r_acc};
  assign w_prod_ext = {{c_ext_w{c_signed & r_s1_prod[c_prod_w-1]}}, r_s1_prod};
  assign w_sum      = w_acc_ext + w_prod_ext;
  assign w_sum_ovf  = c_signed ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];

  always_comb begin
    w_acc_next = w_sum[ACC_W-1:0];
    if (w_sum_ovf && (SAT_EN != 0)) begin
      // Signed: the guard bit is the true sign of the sum.
      w_acc_next = (c_signed && w_sum[ACC_W]) ? c_acc_min : c_acc_max;
    end
  end

  pe_requant #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .SHIFT  (SHIFT),
    .SIGNED (SIGNED)
  ) u_requant (
    .i_acc   (r_acc),
    .o_val   (w_rq_val),
    .o_clamp (w_rq_clamp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_in_o       <= '0;
      pe_filter_o   <= '0;
      activate_o    <= 1'b0;
      mode_o        <= '0;
      pe_out        <= '0;
      pe_out_valid  <= 1'b0;
      pe_out_sat    <= 1'b0;
      r_w           <= '0;
      r_s1_op       <= '0;
      r_s1_prod     <= '0;
      r_acc         <= '0;
      r_ovf         <= 1'b0;
    end else begin
      pe_in_o       <= pe_in;
      pe_filter_o   <= pe_filter;
      activate_o    <= activate;
      mode_o        <= mode_i;

      r_s1_op.valid <= activate;
      r_s1_op.mode  <= mode_i;
      r_s1_prod     <= w_prod;
      if (activate && (mode_i == MODE_LOAD_W)) begin
        r_w <= pe_filter;
      end

      pe_out_valid  <= 1'b0;
      if (r_s1_op.valid) begin
        case (r_s1_op.mode)
          MODE_MAC_STREAM, MODE_MAC_STAT: begin
            r_acc <= w_acc_next;
            if (w_sum_ovf) r_ovf <= 1'b1;
          end
          MODE_DRAIN: begin
            pe_out       <= w_rq_val;
            pe_out_sat   <= w_rq_clamp | r_ovf;
            pe_out_valid <= 1'b1;
            r_acc        <= '0;
            r_ovf        <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign pe_psum = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_pe_mac_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_pe_mac_param
// Description : Self-checking bench for pe_mac_param. Four configurations
//               share one stimulus stream; each is compared against an
//               arithmetic model of accumulate / clamp / wrap / drain.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_pe_mac_param;

  localparam int N = 4;

  // Configurations: d0 unsigned sat, d1 signed sat, d2 signed wrap SHIFT=2,
  // d3 unsigned sat with a 16-bit accumulator.
  int cfg_accw [N] = '{20, 20, 20, 16};
  int cfg_sgn  [N] = '{0, 1, 1, 0};
  int cfg_sat  [N] = '{1, 1, 0, 1};
  int cfg_sh   [N] = '{0, 0, 2, 0};

  logic       clk = 1'b0;
  logic       rst;
  logic       activate;
  logic [1:0] mode_i;
  logic [7:0] pe_in;
  logic [7:0] pe_filter;

  wire [7:0]  f_in   [N];
  wire [7:0]  f_fl   [N];
  wire        f_act  [N];
  wire [1:0]  f_md   [N];
  wire [7:0]  o_out  [N];
  wire        o_valid[N];
  wire        o_sat  [N];
  wire [19:0] o_psum [N];
  wire [15:0] psum3;

  assign o_psum[3] = {4'b0000, psum3};

  always #5 clk = ~clk;

  pe_mac_param #(.DATA_W(8), .ACC_W(20), .SIGNED(0), .SAT_EN(1), .SHIFT(0)) u_d0 (
    .clk(clk), .rst(rst), .activate(activate), .mode_i(mode_i),
    .pe_in(pe_in), .pe_filter(pe_filter),
    .pe_in_o(f_in[0]), .pe_filter_o(f_fl[0]), .activate_o(f_act[0]), .mode_o(f_md[0]),
    .pe_out(o_out[0]), .pe_out_valid(o_valid[0]), .pe_out_sat(o_sat[0]),
    .pe_psum(o_psum[0])
  );

  pe_mac_param #(.DATA_W(8), .ACC_W(20), .SIGNED(1), .SAT_EN(1), .SHIFT(0)) u_d1 (
    .clk(clk), .rst(rst), .activate(activate), .mode_i(mode_i),
    .pe_in(pe_in), .pe_filter(pe_filter),
    .pe_in_o(f_in[1]), .pe_filter_o(f_fl[1]), .activate_o(f_act[1]), .mode_o(f_md[1]),
    .pe_out(o_out[1]), .pe_out_valid(o_valid[1]), .pe_out_sat(o_sat[1]),
    .pe_psum(o_psum[1])
  );

  pe_mac_param #(.DATA_W(8), .ACC_W(20), .SIGNED(1), .SAT_EN(0), .SHIFT(2)) u_d2 (
    .clk(clk), .rst(rst), .activate(activate), .mode_i(mode_i),
    .pe_in(pe_in), .pe_filter(pe_filter),
    .pe_in_o(f_in[2]), .pe_filter_o(f_fl[2]), .activate_o(f_act[2]), .mode_o(f_md[2]),
    .pe_out(o_out[2]), .pe_out_valid(o_valid[2]), .pe_out_sat(o_sat[2]),
    .pe_psum(o_psum[2])
  );

  pe_mac_param #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SAT_EN(1), .SHIFT(0)) u_d3 (
    .clk(clk), .rst(rst), .activate(activate), .mode_i(mode_i),
    .pe_in(pe_in), .pe_filter(pe_filter),
    .pe_in_o(f_in[3]), .pe_filter_o(f_fl[3]), .activate_o(f_act[3]), .mode_o(f_md[3]),
    .pe_out(o_out[3]), .pe_out_valid(o_valid[3]), .pe_out_sat(o_sat[3]),
    .pe_psum(psum3)
  );

  // Reference model state: accumulator as a mathematical value, weight,
  // sticky overflow, and the outputs expected after the next clock edge.
  longint     m_acc  [N];
  logic [7:0] m_w    [N];
  bit         m_ovf  [N];
  logic [19:0] e_psum [N];
  logic [7:0]  e_out  [N];
  logic        e_valid[N];
  logic        e_sat  [N];

  int n_vec = 0;
  int n_err = 0;

  function automatic longint as_val(input logic [7:0] x, input bit sg);
    if (sg) return longint'($signed(x));
    return longint'(x);
  endfunction

  task automatic model_op(input int k, input bit act, input logic [1:0] md,
                          input logic [7:0] a, input logic [7:0] b);
    longint prod, sum, lo, hi, span, v, dlo, dhi;
    bit     sg;
    bit     c;
    sg   = (cfg_sgn[k] != 0);
    span = longint'(1) << cfg_accw[k];
    lo   = sg ? -(span / 2) : 0;
    hi   = sg ? (span / 2) - 1 : span - 1;
    e_valid[k] = 1'b0;
    if (act) begin
      if (md == 2'd0 || md == 2'd1) begin
        prod = as_val(a, sg) * as_val((md == 2'd0) ? b : m_w[k], sg);
        sum  = m_acc[k] + prod;
        if (sum > hi || sum < lo) begin
          m_ovf[k] = 1'b1;
          if (cfg_sat[k] != 0) begin
            sum = (sum > hi) ? hi : lo;
          end else begin
            sum = sum & (span - 1);
            if (sg && sum > hi) sum = sum - span;
          end
        end
        m_acc[k] = sum;
      end else if (md == 2'd2) begin
        m_w[k] = b;
      end else begin
        v   = m_acc[k] >>> cfg_sh[k];
        dlo = sg ? -128 : 0;
        dhi = sg ? 127 : 255;
        c   = 1'b0;
        if (v > dhi) begin
          v = dhi; c = 1'b1;
        end else if (v < dlo) begin
          v = dlo; c = 1'b1;
        end
        e_out[k]   = v[7:0];
        e_sat[k]   = c | m_ovf[k];
        e_valid[k] = 1'b1;
        m_acc[k]   = 0;
        m_ovf[k]   = 1'b0;
      end
    end
    e_psum[k] = 20'(m_acc[k] & (span - 1));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s d%0d psum", tag, k),  32'(o_psum[k]),  32'(e_psum[k]));
      chk($sformatf("%s d%0d valid", tag, k), 32'(o_valid[k]), 32'(e_valid[k]));
      chk($sformatf("%s d%0d out", tag, k),   32'(o_out[k]),   32'(e_out[k]));
      chk($sformatf("%s d%0d sat", tag, k),   32'(o_sat[k]),   32'(e_sat[k]));
    end
  endtask

  // Drive one op, clock it in, check outputs, then advance the model.
  task automatic step(input bit act, input logic [1:0] md,
                      input logic [7:0] a, input logic [7:0] b);
    activate  = act;
    mode_i    = md;
    pe_in     = a;
    pe_filter = b;
    @(posedge clk);
    #1;
    check_outputs("step");
    for (int k = 0; k < N; k++) begin
      chk($sformatf("fwd d%0d in", k),     32'(f_in[k]),  32'(a));
      chk($sformatf("fwd d%0d filter", k), 32'(f_fl[k]),  32'(b));
      chk($sformatf("fwd d%0d act", k),    32'(f_act[k]), 32'(act));
      chk($sformatf("fwd d%0d mode", k),   32'(f_md[k]),  32'(md));
    end
    for (int k = 0; k < N; k++) model_op(k, act, md, a, b);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    activate  = 1'b1;
    mode_i    = 2'd3;
    pe_in     = 8'h5A;
    pe_filter = 8'hA5;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      m_acc[k]   = 0;
      m_w[k]     = 8'h00;
      m_ovf[k]   = 1'b0;
      e_psum[k]  = '0;
      e_out[k]   = '0;
      e_valid[k] = 1'b0;
      e_sat[k]   = 1'b0;
    end
    check_outputs("reset");
    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset d%0d fwd_in", k),   32'(f_in[k]),  32'd0);
      chk($sformatf("reset d%0d fwd_act", k),  32'(f_act[k]), 32'd0);
      chk($sformatf("reset d%0d fwd_mode", k), 32'(f_md[k]),  32'd0);
    end
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Stream MAC: 1*2 + 2*3 + 3*4 = 20.
    step(1'b1, 2'd0, 8'd1, 8'd2);
    step(1'b1, 2'd0, 8'd2, 8'd3);
    step(1'b1, 2'd0, 8'd3, 8'd4);
    step(1'b1, 2'd3, 8'd0, 8'd0);
    chk("stream early_valid", 32'(o_valid[0]), 32'd0);
    step(1'b0, 2'd0, 8'd0, 8'd0);
    chk("stream out", 32'(o_out[0]), 32'd20);
    chk("stream sat", 32'(o_sat[0]), 32'd0);
    chk("stream valid", 32'(o_valid[0]), 32'd1);
    chk("stream psum_clear", 32'(o_psum[0]), 32'd0);
    chk("stream signed_out", 32'(o_out[1]), 32'd20);

    // Stationary weight 5 times 1,2,3 = 30; filter input must be ignored.
    step(1'b1, 2'd2, 8'd0, 8'd5);
    step(1'b1, 2'd1, 8'd1, 8'hAA);
    step(1'b1, 2'd1, 8'd2, 8'h33);
    step(1'b1, 2'd1, 8'd3, 8'hFF);
    step(1'b1, 2'd3, 8'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0, 8'd0);
    chk("stat out", 32'(o_out[0]), 32'd30);
    chk("stat valid", 32'(o_valid[0]), 32'd1);

    // Output clamp: 255*255 drains as 255 with sat.
    step(1'b1, 2'd0, 8'd255, 8'd255);
    step(1'b1, 2'd3, 8'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0, 8'd0);
    chk("clamp out", 32'(o_out[0]), 32'd255);
    chk("clamp sat", 32'(o_sat[0]), 32'd1);

    // 16-bit accumulator saturation.
    step(1'b1, 2'd0, 8'd255, 8'd255);
    step(1'b1, 2'd0, 8'd255, 8'd255);
    step(1'b0, 2'd0, 8'd0, 8'd0);
    chk("acc16 psum", 32'(o_psum[3]), 32'd65535);
    step(1'b1, 2'd3, 8'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0, 8'd0);
    chk("acc16 drain_sat", 32'(o_sat[3]), 32'd1);

    // Signed: -3*4 = -12.
    step(1'b1, 2'd0, 8'hFD, 8'd4);
    step(1'b1, 2'd3, 8'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0, 8'd0);
    chk("signed out", 32'(o_out[1]), 32'hF4);
    chk("signed sat", 32'(o_sat[1]), 32'd0);
    // Signed with SHIFT=2: -128*127 clamps to 8'h80.
    step(1'b1, 2'd0, 8'h80, 8'h7F);
    step(1'b1, 2'd3, 8'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0, 8'd0);
    chk("shift out", 32'(o_out[2]), 32'h80);
    chk("shift sat", 32'(o_sat[2]), 32'd1);

    // Back-to-back drains: second one outputs 0 with valid.
    step(1'b1, 2'd0, 8'd7, 8'd7);
    step(1'b1, 2'd3, 8'd0, 8'd0);
    step(1'b1, 2'd3, 8'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0, 8'd0);
    chk("b2b zero_out", 32'(o_out[0]), 32'd0);
    chk("b2b valid", 32'(o_valid[0]), 32'd1);

    // Bubbles carrying mode=DRAIN must not drain.
    step(1'b0, 2'd3, 8'd9, 8'd9);
    step(1'b1, 2'd0, 8'd1, 8'd2);
    step(1'b0, 2'd3, 8'd9, 8'd9);
    step(1'b1, 2'd0, 8'd2, 8'd3);
    step(1'b0, 2'd3, 8'd9, 8'd9);
    step(1'b1, 2'd0, 8'd3, 8'd4);
    step(1'b0, 2'd3, 8'd9, 8'd9);
    chk("bubble no_drain", 32'(o_valid[0]), 32'd0);
    step(1'b1, 2'd3, 8'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0, 8'd0);
    chk("bubble out", 32'(o_out[0]), 32'd20);

    // Reset one cycle after a drain capture: the drain is discarded.
    step(1'b1, 2'd0, 8'd5, 8'd5);
    step(1'b1, 2'd3, 8'd0, 8'd0);
    do_reset();
    chk("rstmid valid", 32'(o_valid[0]), 32'd0);
    chk("rstmid out", 32'(o_out[0]), 32'd0);
    step(1'b0, 2'd0, 8'd0, 8'd0);
    chk("rstmid after_valid", 32'(o_valid[0]), 32'd0);

    // Randomised traffic, occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end else begin
        step(bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
             8'($urandom), 8'($urandom));
      end
    end
    step(1'b1, 2'd3, 8'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
